// File: rtl/irq_pkg.sv
// irq_pkg: shared state type, arbitration modes and index helper for the interrupt controller
package irq_pkg;

    typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_ACK} irq_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int wrapAdd(input int a, input int b, input int n);
        return (a + b >= n) ? a + b - n : a + b;
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// irq_arbiter: combinational pick of one eligible channel, fixed priority or rotating from rr_ptr
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int N_IRQ    = 4,
    parameter int ARB_MODE = ARB_FIXED,
    localparam int ID_W    = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] eligible,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    logic [ID_W-1:0] base;
    logic [ID_W-1:0] idx;

    assign base = rr_ptr & {ID_W{ARB_MODE == ARB_RR}};

    // Scan from the farthest candidate back to base so the nearest eligible index is written last
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            idx = ID_W'(wrapAdd(int'(base), k, N_IRQ));
            if (eligible[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: synchronises N device IRQ lines, tracks pending/overflow and
// runs a REQ/ACK handshake with the core, pulsing ExtIAck to the served device.
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_IRQ       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ARB_MODE    = ARB_FIXED,
    localparam int ID_W       = $clog2(N_IRQ)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N_IRQ-1:0] ExtIRQ,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic [N_IRQ-1:0] irq_edge,
    input  logic [N_IRQ-1:0] ovf_clr,
    input  logic             cpu_iack,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] ExtIAck,
    output logic [N_IRQ-1:0] irq_pending,
    output logic [N_IRQ-1:0] irq_overflow
);

    logic [SYNC_STAGES-1:0][N_IRQ-1:0] syncQ;
    logic [N_IRQ-1:0] syncCur;
    logic [N_IRQ-1:0] syncDly;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] setVec;
    logic [N_IRQ-1:0] clrVec;
    logic [N_IRQ-1:0] eligible;
    logic [ID_W-1:0]  rrPtr;
    logic [ID_W-1:0]  winner;
    logic             winValid;
    irq_state_t       state;
    irq_state_t       stateNext;

    assign syncCur  = syncQ[SYNC_STAGES-1];
    assign rise     = syncCur & ~syncDly;
    assign setVec   = (irq_edge & rise) | (~irq_edge & syncCur);
    assign clrVec   = (state == IRQ_REQ && cpu_iack) ? N_IRQ'(1) << irq_id : '0;
    assign eligible = irq_pending & irq_mask;

    irq_arbiter #(
        .N_IRQ    (N_IRQ),
        .ARB_MODE (ARB_MODE)
    ) uArb (
        .eligible (eligible),
        .rr_ptr   (rrPtr),
        .winner   (winner),
        .valid    (winValid)
    );

    // Set terms are OR'd last so a new event survives a coincident clear
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            syncQ        <= '0;
            syncDly      <= '0;
            irq_pending  <= '0;
            irq_overflow <= '0;
        end else begin
            syncQ        <= {syncQ[SYNC_STAGES-2:0], ExtIRQ};
            syncDly      <= syncCur;
            irq_pending  <= setVec | (irq_pending & ~clrVec);
            irq_overflow <= (irq_edge & rise & irq_pending & ~clrVec) | (irq_overflow & ~ovf_clr);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state  <= IRQ_IDLE;
            irq_id <= '0;
            rrPtr  <= '0;
        end else begin
            state <= stateNext;
            if (state == IRQ_IDLE && winValid)
                irq_id <= winner;
            if (|clrVec)
                rrPtr <= (irq_id == ID_W'(N_IRQ - 1)) ? '0 : irq_id + 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        irq_req   = 1'b0;
        ExtIAck   = '0;
        case (state)
            IRQ_IDLE: stateNext = winValid ? IRQ_REQ : IRQ_IDLE;
            IRQ_REQ: begin
                irq_req   = 1'b1;
                stateNext = cpu_iack ? IRQ_ACK : IRQ_REQ;
            end
            IRQ_ACK: begin
                ExtIAck   = N_IRQ'(1) << irq_id;
                stateNext = IRQ_IDLE;
            end
            default: stateNext = IRQ_IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: fixed-priority and round-robin instances driven side by side,
// checked every cycle against a behavioural model plus directed literal scenarios.
module tb_irq_controller;

    localparam int N  = 4;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  extIrq = '0;
    logic [N-1:0]  mask = '0;
    logic [N-1:0]  edgeSel = '0;
    logic [N-1:0]  ovfClr = '0;
    logic [1:0]    iack = '0;
    logic [1:0]    req;
    logic [1:0]    id [2];
    logic [N-1:0]  ack [2];
    logic [N-1:0]  pend [2];
    logic [N-1:0]  ovf [2];

    int checks = 0;
    int failures = 0;

    bit [N-1:0] samp [SS+1];
    bit [N-1:0] mPend [2];
    bit [N-1:0] mOvf [2];
    int mPh [2];
    int mCur [2];
    int mPtr [2];

    always #5 clk = ~clk;

    irq_controller #(.N_IRQ(N), .SYNC_STAGES(SS), .ARB_MODE(0)) u0 (
        .CLOCK_50(clk), .reset(reset), .ExtIRQ(extIrq), .irq_mask(mask), .irq_edge(edgeSel),
        .ovf_clr(ovfClr), .cpu_iack(iack[0]), .irq_req(req[0]), .irq_id(id[0]),
        .ExtIAck(ack[0]), .irq_pending(pend[0]), .irq_overflow(ovf[0]));

    irq_controller #(.N_IRQ(N), .SYNC_STAGES(SS), .ARB_MODE(1)) u1 (
        .CLOCK_50(clk), .reset(reset), .ExtIRQ(extIrq), .irq_mask(mask), .irq_edge(edgeSel),
        .ovf_clr(ovfClr), .cpu_iack(iack[1]), .irq_req(req[1]), .irq_id(id[1]),
        .ExtIAck(ack[1]), .irq_pending(pend[1]), .irq_overflow(ovf[1]));

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit [N-1:0] e, input int ptr);
        for (int k = 0; k < N; k++)
            if (e[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    // Model: samp[k] is ExtIRQ as captured k edges ago; mPh 0 idle, 1 requesting, 2 acknowledging
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= SS; k++) samp[k] = '0;
            for (int d = 0; d < 2; d++) begin
                mPend[d] = '0; mOvf[d] = '0; mPh[d] = 0; mCur[d] = 0; mPtr[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit [N-1:0] s, rise, setv, clr, elig;
                s    = samp[SS-1];
                rise = s & ~samp[SS];
                setv = (edgeSel & rise) | (~edgeSel & s);
                clr  = '0;
                if (mPh[d] == 1 && iack[d]) clr[mCur[d]] = 1'b1;
                elig = mPend[d] & mask;
                mOvf[d]  = (edgeSel & rise & mPend[d] & ~clr) | (mOvf[d] & ~ovfClr);
                mPend[d] = setv | (mPend[d] & ~clr);
                if (mPh[d] == 0 && elig != 0) begin
                    mCur[d] = pick(elig, d == 1 ? mPtr[d] : 0);
                    mPh[d]  = 1;
                end else if (mPh[d] == 1 && iack[d]) begin
                    mPh[d]  = 2;
                    mPtr[d] = (mCur[d] + 1) % N;
                end else if (mPh[d] == 2) begin
                    mPh[d] = 0;
                end
            end
            for (int k = SS; k > 0; k--) samp[k] = samp[k-1];
            samp[0] = extIrq;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("m_req%0d", d), int'(req[d]), int'(mPh[d] == 1));
                if (mPh[d] == 1) check($sformatf("m_id%0d", d), int'(id[d]), mCur[d]);
                check($sformatf("m_ack%0d", d), int'(ack[d]), mPh[d] == 2 ? (1 << mCur[d]) : 0);
                check($sformatf("m_pend%0d", d), int'(pend[d]), int'(mPend[d]));
                check($sformatf("m_ovf%0d", d), int'(ovf[d]), int'(mOvf[d]));
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        extIrq = '0; iack = '0; ovfClr = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int seq0 [$];
        int seq1 [$];
        int ids [$];
        int times [$];
        logic prev;
        #1 reset = 1'b0;
        #2;
        check("rst_req", int'(req), 0);
        check("rst_pend0", int'(pend[0]), 0);
        check("rst_ovf1", int'(ovf[1]), 0);
        @(negedge clk);
        reset = 1'b1; mask = '1; edgeSel = '1;

        // Edge on channel 2: request appears on the 4th rising edge
        extIrq = 4'b0100;
        @(negedge clk);
        @(negedge clk); extIrq = '0;
        @(negedge clk); check("t1_req_early", int'(req), 0);
        @(negedge clk); check("t1_req", int'(req), 3); check("t1_id", int'(id[0]), 2);
        iack = 2'b11;
        @(negedge clk); iack = '0;
        check("t1_ack", int'(ack[0]), 4);
        check("t1_pend", int'(pend[0]), 0);
        @(negedge clk); check("t1_ack_gone", int'(ack[0]), 0);

        // Masked channel 0 stays pending without a request until unmasked
        mask = 4'b1110; extIrq = 4'b0001;
        @(negedge clk); extIrq = '0;
        repeat (5) @(negedge clk);
        check("t4_pend", int'(pend[0]), 1);
        check("t4_noreq", int'(req), 0);
        mask = '1;
        @(negedge clk); check("t4_req", int'(req), 3); check("t4_id", int'(id[0]), 0);
        iack = 2'b11;
        @(negedge clk); iack = '0;
        @(negedge clk);

        // Two edges on channel 1 before acknowledge: overflow, single service
        extIrq = 4'b0010; @(negedge clk);
        extIrq = '0;      @(negedge clk);
        extIrq = 4'b0010; @(negedge clk);
        extIrq = '0;
        repeat (3) @(negedge clk);
        check("t5_req", int'(req), 3); check("t5_id", int'(id[0]), 1);
        check("t5_ovf", int'(ovf[0]), 2);
        iack = 2'b11;
        @(negedge clk); iack = '0;
        check("t5_pend", int'(pend[0]), 0);
        repeat (3) @(negedge clk);
        check("t5_one_service", int'(req), 0);
        check("t5_ovf_sticky", int'(ovf[1]), 2);
        ovfClr = 4'b0010;
        @(negedge clk); ovfClr = '0;
        check("t5_ovf_clr", int'(ovf[0]), 0);

        // Asynchronous reset while requesting with channels 1 and 3 pending
        extIrq = 4'b1010;
        repeat (5) @(negedge clk);
        check("t6_req", int'(req), 3);
        check("t6_pend", int'(pend[0]), 10);
        #2 reset = 1'b0;
        #1;
        check("t6_req_drop", int'(req), 0);
        check("t6_ack_drop", int'(ack[0] | ack[1]), 0);
        check("t6_pend_drop", int'(pend[0] | pend[1]), 0);
        extIrq = '0;
        @(negedge clk); reset = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_no_req", int'(req), 0);

        // Level channels 0 and 1 held high, immediate acknowledge
        edgeSel = '0; extIrq = 4'b0011;
        for (int c = 0; c < 60 && (seq0.size() < 4 || seq1.size() < 4); c++) begin
            @(negedge clk);
            if (req[0]) seq0.push_back(int'(id[0]));
            if (req[1]) seq1.push_back(int'(id[1]));
            iack = req;
        end
        iack = '0;
        check("t3_count", int'(seq1.size() >= 4 && seq0.size() >= 4), 1);
        for (int i = 0; i < 4 && i < seq1.size(); i++) check($sformatf("t3_rr%0d", i), seq1[i], i % 2);
        for (int i = 0; i < 4 && i < seq0.size(); i++) check($sformatf("t3_fix%0d", i), seq0[i], 0);
        doReset();

        // Simultaneous edges on channels 1 and 3 under fixed priority
        edgeSel = '1; extIrq = 4'b1010; prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req[0] && !prev) begin ids.push_back(int'(id[0])); times.push_back(c); end
            prev = req[0];
            iack = req;
        end
        iack = '0; extIrq = '0;
        check("t2_count", ids.size(), 2);
        if (ids.size() == 2) begin
            check("t2_first", ids[0], 1);
            check("t2_second", ids[1], 3);
            check("t2_gap", int'(times[1] - times[0] >= 3), 1);
        end
        doReset();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            extIrq ^= N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 19) == 0) mask = N'($urandom | $urandom);
            if ($urandom_range(0, 49) == 0) edgeSel = N'($urandom);
            ovfClr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            iack[0] = ($urandom_range(0, 2) == 0);
            iack[1] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
